// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and helpers for the HH:MM display scanner
package display_pkg;

   localparam int DIGIT_W  = 4;
   localparam int N_DIGITS = 4;

   localparam logic [DIGIT_W-1:0] BCD_BLANK = 4'hF;

   localparam logic [1:0] SLOT_MIN_ONES = 2'd0;
   localparam logic [1:0] SLOT_MIN_TENS = 2'd1;
   localparam logic [1:0] SLOT_HR_ONES  = 2'd2;
   localparam logic [1:0] SLOT_HR_TENS  = 2'd3;

   // Active-low one-hot anode pattern for a slot.
   function automatic logic [N_DIGITS-1:0] anode_n(input logic [1:0] slot);
      return ~(4'b0001 << slot);
   endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - terminal-count divider producing a one-cycle tick when enabled
module tick_gen #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/display_scan_mux.sv
// rtl/display_scan_mux.sv - 4-digit scan multiplexer with frame snapshot, blinking and
// leading-zero blanking, anodes delayed one cycle behind bcd to match the decoder
module display_scan_mux
   import display_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_DIV   = 250
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DIGIT_W*N_DIGITS-1:0]   digits,
   input  logic                          blink_en,
   input  logic [N_DIGITS-1:0]           blink_mask,
   input  logic                          lz_blank,
   input  logic                          colon_blink,
   output logic [DIGIT_W-1:0]            bcd,
   output logic [N_DIGITS-1:0]           an_n,
   output logic                          dp_n
);

   logic                        slot_adv;
   logic                        frame_wrap;
   logic                        blink_tick;
   logic [1:0]                  slot;
   logic                        phase;
   logic [DIGIT_W*N_DIGITS-1:0] snapshot;
   logic [DIGIT_W-1:0]          digit;
   logic [DIGIT_W-1:0]          sel;
   logic [1:0]                  slot_d1;
   logic                        valid_d1;

   tick_gen #(.DIV(REFRESH_DIV)) u_refresh (
      .clk  (clk),
      .rst  (rst),
      .en   (1'b1),
      .tick (slot_adv)
   );

   assign frame_wrap = slot_adv && (slot == SLOT_HR_TENS);

   tick_gen #(.DIV(BLINK_DIV)) u_blink (
      .clk  (clk),
      .rst  (rst),
      .en   (frame_wrap),
      .tick (blink_tick)
   );

   // Snapshot and phase change only at frame boundaries so a frame never tears.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot     <= SLOT_MIN_ONES;
         phase    <= 1'b1;
         snapshot <= '0;
      end else begin
         if (slot_adv)   slot     <= slot + 2'd1;
         if (frame_wrap) snapshot <= digits;
         if (blink_tick) phase    <= ~phase;
      end
   end

   assign digit = snapshot[{slot, 2'b00} +: DIGIT_W];

   always_comb begin
      sel = digit;
      if (blink_en && blink_mask[slot] && !phase) begin
         sel = BCD_BLANK;
      end else if (lz_blank && (slot == SLOT_HR_TENS) && (digit == 4'd0)) begin
         sel = BCD_BLANK;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bcd      <= BCD_BLANK;
         slot_d1  <= SLOT_MIN_ONES;
         valid_d1 <= 1'b0;
      end else begin
         bcd      <= sel;
         slot_d1  <= slot;
         valid_d1 <= 1'b1;
      end
   end

   // valid_d1 keeps the anodes dark until the first real digit reaches the decoder output.
   always_ff @(posedge clk) begin
      if (rst || !valid_d1) begin
         an_n <= '1;
         dp_n <= 1'b1;
      end else begin
         an_n <= anode_n(slot_d1);
         dp_n <= ~((slot_d1 == SLOT_HR_ONES) && (colon_blink ? phase : 1'b1));
      end
   end

endmodule
